spi_alu_arbiter: RTL and testbench
==================================

SPI_ALU_ARBITER -- requirements
Module: spi_alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the SPI ALU slave (range 2..8).
REQ-002 SHALL have parameter DATA_W, default 32, width of each operand and of the result.
REQ-003 SHALL have clock  input  1  system clock; every SPI bit is one clock cycle.
REQ-004 SHALL have reset  input  1  asynchronous, active-low.
REQ-005 SHALL have req_valid  input  NUM_REQ  per-requester operation pending.
REQ-006 SHALL have req_ready  output  NUM_REQ  per-requester accept strobe, at most one bit high.
REQ-007 SHALL have req_opcode  input  NUM_REQ x 2  per-requester ALU opcode.
REQ-008 SHALL have req_opa, req_opb  input  NUM_REQ x DATA_W  per-requester operands.
REQ-009 SHALL have rsp_valid  output  NUM_REQ  one-cycle result strobe to the owning requester.
REQ-010 SHALL have rsp_data  output  DATA_W  shared result bus, qualified by rsp_valid.
REQ-011 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have spi  IF_SPI.MASTER  --  nss (active-low), mosi, miso to the ALU slave.

Function
REQ-013 SHALL implement states IDLE, SEND, GAP, RECV, DONE.
REQ-014 In IDLE with any req_valid high, SHALL raise req_ready for exactly one winner in that cycle (combinational); the acceptance edge latches frame = {opcode, opa, opb} (2+2*DATA_W = 66 bits), owner index, and moves to SEND.
REQ-015 Requesters SHALL hold valid and operands stable until req_ready; req_ready SHALL be low in every non-IDLE state.
REQ-016 SEND: 2+2*DATA_W cycles, nss low, mosi = frame bit (FRAME_W-1-cnt), MSB first, cnt 0..FRAME_W-1; after the last bit go to GAP.
REQ-017 GAP: exactly one cycle, nss high, mosi low.
REQ-018 RECV: DATA_W cycles, nss low, miso sampled at each rising edge into result MSB first.
REQ-019 DONE: one cycle, rsp_data = result, rsp_valid[owner] high; then IDLE.
REQ-020 rsp_data SHALL hold its value until the next DONE.
REQ-021 Latency: with acceptance edge t0, rsp_valid SHALL be high in the cycle beginning at edge t0+2*DATA_W+35 (t0+99 at default); throughput one operation per 2*DATA_W+37 cycles.
REQ-022 Default arbitration SHALL be round-robin: search starts at last owner+1 modulo NUM_REQ; pointer updates only in DONE.
REQ-023 A requester deasserting req_valid before grant SHALL lose nothing and SHALL not be granted.
REQ-024 nss SHALL be high and mosi low in IDLE, GAP, DONE.

Reset
REQ-025 On reset low, SHALL immediately force state IDLE, nss high, mosi low, req_ready 0, rsp_valid 0, rsp_data 0, busy 0, cnt 0, RR pointer to requester 0.
REQ-026 Reset mid-transaction SHALL abort it with no rsp_valid ever issued for it.

Configuration
REQ-027 With SPI_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest index wins, pointer unused; without it, round-robin per REQ-022.

Structure
REQ-028 Package spi_arb_pkg SHALL hold the state enum (one-hot), OPCODE_W=2, FRAME_W/RESULT_W derivation functions.
REQ-029 Grant selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant out), honoring SPI_ARB_FIXED_PRIO_EN.

Verification
REQ-030 Single op: req 1 valid, opcode 2'b01, opa 0x0000_0005, opb 0x0000_0003, slave returns 0x0000_0008 -> req_ready[1] one cycle, mosi stream 66'h1_0000_0005_0000_0003 MSB first, rsp_valid[1] at t0+99, rsp_data 0x8.
REQ-031 Contention: all four valid simultaneously from reset -> grants in order 0,1,2,3, each 101 cycles apart; with SPI_ARB_FIXED_PRIO_EN and 0 re-requesting, order 0,0,0...
REQ-032 Framing: check nss low for exactly 66 cycles, high exactly 1 cycle, low exactly 32 cycles per operation.
REQ-033 Reset at cycle 40 of SEND -> nss high same cycle, no rsp_valid, next op after reset starts with requester 0 and completes correctly.
REQ-034 Withdrawn request: req 2 valid for 10 cycles during another op then dropped -> req 2 never granted, no rsp_valid[2].
REQ-035 Result hold: after DONE, rsp_data stays 0x8 through the next 98 cycles until the next DONE.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared definitions for the SPI ALU arbiter.
//   OPCODE_W     - width of the ALU opcode carried at the front of each frame
//   state_e      - one-hot controller state
//   frame_w()    - bits shifted out per operation: opcode + two operands
//   result_w()   - bits shifted back from the slave per operation
package spi_arb_pkg;

   localparam int unsigned OPCODE_W = 2;

   typedef enum logic [4:0] {
      StIdle = 5'b00001,
      StSend = 5'b00010,
      StGap  = 5'b00100,
      StRecv = 5'b01000,
      StDone = 5'b10000
   } state_e;

   function automatic int unsigned frame_w(input int unsigned data_w);
      return OPCODE_W + 2 * data_w;
   endfunction

   function automatic int unsigned result_w(input int unsigned data_w);
      return data_w;
   endfunction

endpackage

// File: rtl/spi_alu_arbiter_if.sv
// spi_alu_arbiter_if: SPI link between the arbiter (master) and the ALU slave.
//   nss  - frame select, active low, driven by the master
//   mosi - serial data master -> slave
//   miso - serial data slave -> master
interface spi_alu_arbiter_if;

   logic nss;
   logic mosi;
   logic miso;

   modport master (
      output nss,
      output mosi,
      input  miso
   );

   modport slave (
      input  nss,
      input  mosi,
      output miso
   );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant selection.
//   i_req   - request vector
//   i_ptr   - index where the round-robin search starts
//   o_grant - one-hot grant, zero when no request is pending
// Build option: SPI_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) and
// ignores i_ptr.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);

   logic w_found;

`ifdef SPI_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && i_req[j]) begin
            o_grant[j] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end
`else
   // First pass covers indices at or above the pointer, second pass wraps to the bottom.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && i_req[j] && (PTR_W'(j) >= i_ptr)) begin
            o_grant[j] = 1'b1;
            w_found    = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && i_req[j]) begin
            o_grant[j] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/spi_alu_arbiter.sv
// spi_alu_arbiter: shares one SPI-attached ALU slave between NUM_REQ requesters.
// An accepted request is shifted out as {opcode, opa, opb} MSB first, followed by a
// one-cycle gap and DATA_W result bits shifted in; the result is returned on a
// one-cycle rsp_valid strobe to the owner and held on o_rsp_data.
//   clock, reset   - system clock, asynchronous active-low reset
//   i_req_valid    - per-requester operation pending
//   o_req_ready    - per-requester accept strobe (one-hot, IDLE only)
//   i_req_opcode   - per-requester opcode, packed NUM_REQ x OPCODE_W
//   i_req_opa/opb  - per-requester operands, packed NUM_REQ x DATA_W
//   o_rsp_valid    - one-cycle result strobe to the owning requester
//   o_rsp_data     - shared result bus, held until the next result
//   o_busy         - controller not idle
//   spi            - SPI master port to the ALU slave
// Build option: SPI_ARB_FIXED_PRIO_EN -> fixed priority instead of round-robin.
module spi_alu_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ*OPCODE_W-1:0]   i_req_opcode,
   input  logic [NUM_REQ*DATA_W-1:0]     i_req_opa,
   input  logic [NUM_REQ*DATA_W-1:0]     i_req_opb,
   output logic [NUM_REQ-1:0]            o_rsp_valid,
   output logic [DATA_W-1:0]             o_rsp_data,
   output logic                          o_busy,
   spi_alu_arbiter_if.master             spi
);

   localparam int unsigned FRAME_W  = frame_w(DATA_W);
   localparam int unsigned RESULT_W = result_w(DATA_W);
   localparam int unsigned PTR_W    = $clog2(NUM_REQ);
   localparam int unsigned CNT_W    = $clog2(FRAME_W);

   state_e               r_state;
   state_e               w_state_next;
   logic [FRAME_W-1:0]   r_frame;
   logic [PTR_W-1:0]     r_owner;
   logic [CNT_W-1:0]     r_cnt;
   logic [RESULT_W-1:0]  r_result;
   logic [RESULT_W-1:0]  r_rsp_data;
   logic [PTR_W-1:0]     w_ptr;
   logic [NUM_REQ-1:0]   w_grant;
   logic [PTR_W-1:0]     w_grant_idx;
   logic [FRAME_W-1:0]   w_frame;
   logic                 w_send_last;
   logic                 w_recv_last;

   assign w_send_last = (r_cnt == CNT_W'(FRAME_W - 1));
   assign w_recv_last = (r_cnt == CNT_W'(RESULT_W - 1));

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .i_req   (i_req_valid),
      .i_ptr   (w_ptr),
      .o_grant (w_grant)
   );

   // Winner index and its frame, used only on the acceptance edge.
   always_comb begin
      w_grant_idx = '0;
      w_frame     = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_grant[j]) begin
            w_grant_idx = PTR_W'(j);
            w_frame     = {i_req_opcode[j*OPCODE_W +: OPCODE_W],
                           i_req_opa[j*DATA_W +: DATA_W],
                           i_req_opb[j*DATA_W +: DATA_W]};
         end
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (|i_req_valid) w_state_next = StSend;
         StSend:  if (w_send_last)  w_state_next = StGap;
         StGap:                     w_state_next = StRecv;
         StRecv:  if (w_recv_last)  w_state_next = StDone;
         StDone:                    w_state_next = StIdle;
         default:                   w_state_next = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_rsp_data  = r_rsp_data;
      o_busy      = 1'b1;
      spi.nss     = 1'b1;
      spi.mosi    = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_busy = 1'b0;
            // Gated so no accept strobe leaks out while reset is held.
            o_req_ready = reset ? w_grant : '0;
         end
         StSend: begin
            spi.nss  = 1'b0;
            spi.mosi = r_frame[FRAME_W-1];
         end
         StRecv: spi.nss = 1'b0;
         StDone: begin
            o_rsp_valid = NUM_REQ'(1) << r_owner;
            o_rsp_data  = r_result;
         end
         default: ;
      endcase
   end

   // Datapath: frame shifter, bit counter, result shifter and held result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_frame    <= '0;
         r_owner    <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_rsp_data <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (|i_req_valid) begin
                  r_frame <= w_frame;
                  r_owner <= w_grant_idx;
                  r_cnt   <= '0;
               end
            end
            StSend: begin
               r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
               r_cnt   <= w_send_last ? '0 : r_cnt + 1'b1;
            end
            StGap: r_cnt <= '0;
            StRecv: begin
               r_result <= {r_result[RESULT_W-2:0], spi.miso};
               r_cnt    <= r_cnt + 1'b1;
            end
            StDone: begin
               r_rsp_data <= r_result;
               r_cnt      <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [PTR_W-1:0] r_ptr;

   // Search start moves past the owner only once its result has been delivered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (r_state == StDone) begin
         r_ptr <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
   end

   assign w_ptr = r_ptr;
`endif

endmodule

// File: tb/tb_spi_alu_arbiter.sv
// tb_spi_alu_arbiter: directed bench with a cycle-level reference model of the
// arbiter, a behavioural ALU slave on the SPI link and literal checks per scenario.
module tb_spi_alu_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int FRAME_W = 2 + 2 * DATA_W;
   localparam int DONE_D  = FRAME_W + 1 + DATA_W;   // offset of DONE from the first SEND cycle

   logic                        clock = 1'b0;
   logic                        reset = 1'b0;
   logic [NUM_REQ-1:0]          i_req_valid;
   logic [NUM_REQ-1:0]          o_req_ready;
   logic [NUM_REQ*2-1:0]        i_req_opcode;
   logic [NUM_REQ*DATA_W-1:0]   i_req_opa;
   logic [NUM_REQ*DATA_W-1:0]   i_req_opb;
   logic [NUM_REQ-1:0]          o_rsp_valid;
   logic [DATA_W-1:0]           o_rsp_data;
   logic                        o_busy;

   spi_alu_arbiter_if u_spi ();

   spi_alu_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W)
   ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_opcode (i_req_opcode),
      .i_req_opa    (i_req_opa),
      .i_req_opb    (i_req_opb),
      .o_rsp_valid  (o_rsp_valid),
      .o_rsp_data   (o_rsp_data),
      .o_busy       (o_busy),
      .spi          (u_spi)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave ALU behaviour: 00 and, 01 add, 10 sub, 11 xor.
   function automatic logic [DATA_W-1:0] alu(input logic [FRAME_W-1:0] f);
      logic [1:0]        op;
      logic [DATA_W-1:0] a, b;
      op = f[FRAME_W-1 -: 2];
      a  = f[2*DATA_W-1 -: DATA_W];
      b  = f[DATA_W-1:0];
      case (op)
         2'b00:   return a & b;
         2'b01:   return a + b;
         2'b10:   return a - b;
         default: return a ^ b;
      endcase
   endfunction

   // Requesters
   int                ops_left [NUM_REQ];
   logic [1:0]        op_code  [NUM_REQ];
   logic [DATA_W-1:0] op_a     [NUM_REQ];
   logic [DATA_W-1:0] op_b     [NUM_REQ];
   logic [NUM_REQ-1:0] rdy_seen = '0;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         i_req_valid[i]               = (ops_left[i] != 0);
         i_req_opcode[i*2 +: 2]       = op_code[i];
         i_req_opa[i*DATA_W +: DATA_W] = op_a[i];
         i_req_opb[i*DATA_W +: DATA_W] = op_b[i];
      end
   end

   // After each accept, consume one op and change the operand for the next one.
   always @(posedge clock) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rdy_seen[i]) begin
            if (ops_left[i] > 0) ops_left[i]--;
            op_a[i] = op_a[i] + 32'h11;
         end
      end
   end

   // SPI slave: collects the frame, checks framing lengths, returns alu(frame).
   int                 s_phase = 0;
   int                 s_len   = 0;
   int                 s_hi    = 0;
   logic [FRAME_W-1:0] s_rx    = '0;
   logic [DATA_W-1:0]  s_res   = '0;
   logic [FRAME_W-1:0] s_frames [$];

   initial u_spi.miso = 1'b0;

   always @(negedge clock) begin
      if (!reset) begin
         s_phase = 0;
         s_len   = 0;
         s_hi    = 0;
         u_spi.miso = 1'b0;
      end else if (!u_spi.nss) begin
         if (s_phase == 0) begin
            s_rx = {s_rx[FRAME_W-2:0], u_spi.mosi};
            s_len++;
            u_spi.miso = 1'b0;
         end else begin
            if (s_len == 0) check("gap_len", s_hi, 1);
            u_spi.miso = (s_len < DATA_W) ? s_res[DATA_W-1-s_len] : 1'b0;
            s_len++;
         end
      end else begin
         u_spi.miso = 1'b0;
         if (s_len != 0) begin
            if (s_phase == 0) begin
               check("send_len", s_len, FRAME_W);
               s_frames.push_back(s_rx);
               s_res   = alu(s_rx);
               s_phase = 1;
               s_hi    = 1;
            end else begin
               check("recv_len", s_len, DATA_W);
               s_phase = 0;
            end
            s_len = 0;
         end else if (s_phase == 1) begin
            s_hi++;
         end
      end
   end

   // Reference model: an operation occupies offsets 0..DONE_D after acceptance.
   bit                 m_busy  = 0;
   int                 m_d     = 0;
   int                 m_owner = 0;
   int                 m_start = 0;
   int                 m_cyc   = 0;
   logic [FRAME_W-1:0] m_frame = '0;
   logic [DATA_W-1:0]  m_rsp   = '0;

   int                g_owner [$];
   int                g_cyc   [$];
   int                r_cyc   [$];
   logic [DATA_W-1:0] r_data  [$];
   int                rdy_cnt [NUM_REQ];
   int                rsp_cnt [NUM_REQ];
   int                rsp_total = 0;

   function automatic int pick();
`ifdef SPI_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NUM_REQ; i++) if (ops_left[i] != 0) return i;
`else
      for (int k = 0; k < NUM_REQ; k++)
         if (ops_left[(m_start + k) % NUM_REQ] != 0) return (m_start + k) % NUM_REQ;
`endif
      return -1;
   endfunction

   always @(negedge clock) begin
      logic [NUM_REQ-1:0] e_ready, e_rv;
      logic               e_nss, e_mosi, e_busy;
      int                 w;
      m_cyc++;
      e_ready = '0;
      e_rv    = '0;
      w       = -1;
      if (!reset) begin
         m_busy  = 0;
         m_start = 0;
         m_rsp   = '0;
         e_nss   = 1'b1;
         e_mosi  = 1'b0;
         e_busy  = 1'b0;
      end else begin
         if (!m_busy) begin
            w = pick();
            if (w >= 0) e_ready[w] = 1'b1;
         end
         e_busy = m_busy;
         e_nss  = !(m_busy && (m_d < FRAME_W || (m_d > FRAME_W && m_d < DONE_D)));
         e_mosi = (m_busy && m_d < FRAME_W) ? m_frame[FRAME_W-1-m_d] : 1'b0;
         if (m_busy && m_d == DONE_D) begin
            m_rsp          = alu(m_frame);
            e_rv[m_owner]  = 1'b1;
         end
      end
      check("req_ready", o_req_ready, e_ready);
      check("rsp_valid", o_rsp_valid, e_rv);
      check("rsp_data", o_rsp_data, m_rsp);
      check("busy", o_busy, e_busy);
      check("nss", u_spi.nss, e_nss);
      check("mosi", u_spi.mosi, e_mosi);

      rdy_seen = o_req_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (o_req_ready[i]) begin
            g_owner.push_back(i);
            g_cyc.push_back(m_cyc);
            rdy_cnt[i]++;
         end
         if (o_rsp_valid[i]) begin
            rsp_cnt[i]++;
            rsp_total++;
            r_cyc.push_back(m_cyc);
            r_data.push_back(o_rsp_data);
         end
      end

      if (reset) begin
         if (w >= 0) begin
            m_busy  = 1;
            m_d     = 0;
            m_owner = w;
            m_frame = {op_code[w], op_a[w], op_b[w]};
         end else if (m_busy) begin
            if (m_d == DONE_D) begin
               m_busy  = 0;
               m_start = (m_owner + 1) % NUM_REQ;
            end else begin
               m_d++;
            end
         end
      end
   end

   task automatic clear_logs();
      g_owner.delete();
      g_cyc.delete();
      r_cyc.delete();
      r_data.delete();
      s_frames.delete();
      rsp_total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rdy_cnt[i] = 0;
         rsp_cnt[i] = 0;
      end
   endtask

   task automatic do_reset();
      @(posedge clock);
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic wait_rsp(input int n, input int budget, input string name);
      int k = 0;
      while (rsp_total < n && k < budget) begin
         @(negedge clock);
         #1;
         k++;
      end
      check(name, rsp_total >= n, 1'b1);
   endtask

   task automatic wait_grant(input int n, input int budget, input string name);
      int k = 0;
      while (g_owner.size() < n && k < budget) begin
         @(negedge clock);
         #1;
         k++;
      end
      check(name, g_owner.size() >= n, 1'b1);
   endtask

`ifdef SPI_ARB_FIXED_PRIO_EN
   int exp_ord [6] = '{0, 0, 0, 1, 2, 3};
`else
   int exp_ord [6] = '{0, 1, 2, 3, 0, 0};
`endif

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         ops_left[i] = 0;
         op_code[i]  = 2'(i);
         op_a[i]     = 32'h1000 * (i + 1);
         op_b[i]     = 32'h10 + i;
      end
      clear_logs();

      // Reset state
      repeat (2) @(negedge clock);
      #1;
      check("rst_busy", o_busy, 1'b0);
      check("rst_nss", u_spi.nss, 1'b1);
      check("rst_mosi", u_spi.mosi, 1'b0);
      check("rst_rsp_data", o_rsp_data, '0);
      check("rst_rsp_valid", o_rsp_valid, '0);
      @(posedge clock);
      #1 reset = 1'b1;

      // Single op on requester 1, followed by a second op to exercise result hold.
      @(posedge clock);
      #2;
      op_code[1]  = 2'b01;
      op_a[1]     = 32'h5;
      op_b[1]     = 32'h3;
      ops_left[1] = 2;
      wait_rsp(1, 200, "single_timeout");
      check("single_owner", g_owner[0], 1);
      check("single_latency", r_cyc[0] - g_cyc[0], 100);
      check("single_result", r_data[0], 32'h8);
      check("single_frame", s_frames[0], 66'h1_0000_0005_0000_0003);
      repeat (98) @(negedge clock);
      #1;
      check("hold_data", o_rsp_data, 32'h8);
      check("hold_no_valid", o_rsp_valid, '0);
      wait_rsp(2, 50, "second_timeout");
      check("second_result", r_data[1], 32'h19);
      check("second_spacing", g_cyc[1] - g_cyc[0], 101);
      check("single_ready_cnt", rdy_cnt[1], 2);

      // Contention from reset
      do_reset();
      clear_logs();
      @(posedge clock);
      #2;
      ops_left[0] = 3;
      ops_left[1] = 1;
      ops_left[2] = 1;
      ops_left[3] = 1;
      wait_rsp(6, 700, "contention_timeout");
      for (int i = 0; i < 6; i++) begin
         check($sformatf("order_%0d", i), g_owner[i], exp_ord[i]);
         if (i > 0) check($sformatf("spacing_%0d", i), g_cyc[i] - g_cyc[i-1], 101);
      end

      // Reset in the middle of SEND
      repeat (3) @(negedge clock);
      clear_logs();
      @(posedge clock);
      #2 ops_left[1] = 1;
      wait_grant(1, 20, "abort_grant_timeout");
      repeat (41) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("abort_nss", u_spi.nss, 1'b1);
      check("abort_busy", o_busy, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #2;
      op_code[0]  = 2'b10;
      op_a[0]     = 32'h100;
      op_b[0]     = 32'h1;
      op_code[2]  = 2'b11;
      op_a[2]     = 32'hF0F0;
      op_b[2]     = 32'h0FF0;
      ops_left[0] = 1;
      ops_left[2] = 1;
      wait_rsp(2, 300, "post_reset_timeout");
      check("post_reset_first", g_owner[1], 0);
      check("post_reset_second", g_owner[2], 2);
      check("post_reset_r0", r_data[0], 32'hFF);
      check("post_reset_r1", r_data[1], 32'hFF00);
      check("aborted_no_rsp", rsp_cnt[1], 0);

      // Withdrawn request
      repeat (3) @(negedge clock);
      clear_logs();
      @(posedge clock);
      #2 ops_left[3] = 1;
      wait_grant(1, 20, "withdraw_grant_timeout");
      repeat (5) @(posedge clock);
      #2 ops_left[2] = 1;
      repeat (10) @(posedge clock);
      #2 ops_left[2] = 0;
      wait_rsp(1, 200, "withdraw_timeout");
      repeat (20) @(negedge clock);
      check("withdraw_owner", g_owner[0], 3);
      check("withdraw_grants", g_owner.size(), 1);
      check("withdraw_no_ready", rdy_cnt[2], 0);
      check("withdraw_no_rsp", rsp_cnt[2], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
